// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared constants and types for the ALUOPS execute-stage arithmetic blocks.
//   Contents:
//     WIDTH      - operand/result width of the divider (only 64 is supported)
//     div_state_t- divider FSM encoding (IDLE/RUN/DONE)
//     DIVZ_QUOT  - quotient reported for a divide-by-zero (all ones)
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [WIDTH-1:0] DIVZ_QUOT = '1;

endpackage

// File: rtl/divu64_seq_if.sv
// ---------------------------------------------------------------------------
// divu64_seq_if
//   Request/response bundle of the sequential divider.
//   Signals:
//     start        - request, honoured only while the divider is idle
//     in1, in2     - dividend / divisor, captured with start
//     busy         - divider is iterating
//     done         - one-cycle pulse, results valid
//     quot, rem    - quotient / remainder, held until the next result
//     z_div_flag   - quot == 0
//     dz_div_flag  - last operation was a divide by zero
//   Modports:
//     master - the requester (execute stage / testbench)
//     slave  - the divider
// ---------------------------------------------------------------------------
interface divu64_seq_if;
  import alu_pkg::*;

  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             z_div_flag;
  logic             dz_div_flag;

  modport master (
    output start, in1, in2,
    input  busy, done, quot, rem, z_div_flag, dz_div_flag
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, quot, rem, z_div_flag, dz_div_flag
  );

endinterface

// File: rtl/divu64_step.sv
// ---------------------------------------------------------------------------
// divu64_step
//   One restoring shift-subtract iteration, purely combinational.
//   Ports:
//     i_rem   [64:0] - current partial remainder
//     i_q     [63:0] - current quotient/shift register
//     i_div   [63:0] - divisor
//     o_rem   [64:0] - next partial remainder
//     o_q     [63:0] - next quotient/shift register
// ---------------------------------------------------------------------------
module divu64_step
  import alu_pkg::*;
(
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;

  // The remainder always stays below the divisor, so the shifted value fits
  // in 65 bits; the subtraction is carried one bit wider so its top bit is a
  // clean borrow (shifted < divisor).
  always_comb begin
    w_shifted = {i_rem[WIDTH-1:0], i_q[WIDTH-1]};
    w_diff    = {i_rem, i_q[WIDTH-1]} - {2'b00, i_div};
    w_borrow  = w_diff[WIDTH+1];
    if (w_borrow) begin
      o_rem = w_shifted;
      o_q   = {i_q[WIDTH-2:0], 1'b0};
    end else begin
      o_rem = w_diff[WIDTH:0];
      o_q   = {i_q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divu64_seq.sv
// ---------------------------------------------------------------------------
// divu64_seq
//   Multi-cycle unsigned 64-bit divider (restoring, one quotient bit per
//   clock) with a start/busy/done handshake.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - divu64_seq_if.slave (start/in1/in2 in; busy/done/quot/rem/
//              z_div_flag/dz_div_flag out)
//   Configuration macro:
//     DIVU64_EARLY_OUT_EN - when defined, a dividend smaller than a nonzero
//                           divisor finishes immediately (quot 0, rem in1).
//   Latency: 64 RUN cycles + 1 DONE cycle; divide-by-zero (and early-out)
//   goes straight to DONE.
// ---------------------------------------------------------------------------
module divu64_seq
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  divu64_seq_if.slave  bus
);

  div_state_t       r_state;
  div_state_t       w_next;
  logic [6:0]       r_cnt;
  logic [WIDTH:0]   r_work_rem;
  logic [WIDTH-1:0] r_work_q;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_z;
  logic             r_dz;

  logic             w_accept;
  logic             w_divz;
  logic             w_last;
`ifdef DIVU64_EARLY_OUT_EN
  logic             w_early;
`endif
  logic [WIDTH:0]   w_step_rem;
  logic [WIDTH-1:0] w_step_q;

  divu64_step u_step (
    .i_rem (r_work_rem),
    .i_q   (r_work_q),
    .i_div (r_div),
    .o_rem (w_step_rem),
    .o_q   (w_step_q)
  );

  // State register; reset lands in IDLE from any state, including mid-RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode. A start is only honoured in IDLE; divide-by-zero
  // takes priority over the optional early-out, and both skip RUN entirely.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_divz   = 1'b0;
    w_last   = 1'b0;
`ifdef DIVU64_EARLY_OUT_EN
    w_early  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (bus.in2 == '0) begin
            w_divz = 1'b1;
            w_next = DONE;
          end
`ifdef DIVU64_EARLY_OUT_EN
          else if (bus.in1 < bus.in2) begin
            w_early = 1'b1;
            w_next  = DONE;
          end
`endif
          else begin
            w_next = RUN;
          end
        end
      end
      RUN: begin
        if (r_cnt == 7'd63) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand capture, iteration and result registers. Visible results only
  // change on the edge that enters DONE, so they stay put while a new
  // division is iterating in the working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_work_rem <= '0;
      r_work_q   <= '0;
      r_div      <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_z        <= 1'b1;
      r_dz       <= 1'b0;
    end else if (w_accept) begin
      r_work_q   <= bus.in1;
      r_div      <= bus.in2;
      r_work_rem <= '0;
      r_cnt      <= '0;
      if (w_divz) begin
        r_quot <= DIVZ_QUOT;
        r_rem  <= bus.in1;
        r_z    <= 1'b0;
        r_dz   <= 1'b1;
      end
`ifdef DIVU64_EARLY_OUT_EN
      else if (w_early) begin
        r_quot <= '0;
        r_rem  <= bus.in1;
        r_z    <= 1'b1;
        r_dz   <= 1'b0;
      end
`endif
    end else if (r_state == RUN) begin
      r_work_rem <= w_step_rem;
      r_work_q   <= w_step_q;
      r_cnt      <= r_cnt + 7'd1;
      if (w_last) begin
        r_quot <= w_step_q;
        r_rem  <= w_step_rem[WIDTH-1:0];
        r_z    <= (w_step_q == '0);
        r_dz   <= 1'b0;
      end
    end
  end

  assign bus.busy        = (r_state == RUN);
  assign bus.done        = (r_state == DONE);
  assign bus.quot        = r_quot;
  assign bus.rem         = r_rem;
  assign bus.z_div_flag  = r_z;
  assign bus.dz_div_flag = r_dz;

endmodule

// File: tb/tb_divu64_seq.sv
// ---------------------------------------------------------------------------
// tb_divu64_seq
//   Self-checking bench for divu64_seq: a table of directed divisions with
//   hand-computed results, plus hand-written sequences for start-while-busy
//   and reset in the middle of an iteration. Latency expectations follow
//   DIVU64_EARLY_OUT_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_divu64_seq;
  import alu_pkg::*;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    logic        z;
    logic        dz;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  divu64_seq_if bus ();

  divu64_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one value and reports it on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
    end
  endtask

  // Expected done cycle for an operation, counted from the accept edge.
  function automatic int expLatency(input logic [63:0] a, input logic [63:0] b);
    if (b == 64'd0) return 1;
`ifdef DIVU64_EARLY_OUT_EN
    if (a < b) return 1;
`endif
    return 65;
  endfunction

  // Launches one division from IDLE and follows it to done. Operands are
  // scrambled right after the accept edge to show they are not re-sampled.
  // doneCyc is -1 if done never arrives within the bound; pulseOk reports
  // whether done dropped again one cycle later.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               output int doneCyc, output int busyCnt,
                               output int firstBusy, output bit pulseOk);
    doneCyc   = -1;
    busyCnt   = 0;
    firstBusy = -1;
    pulseOk   = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        bus.in1   = 64'hDEAD_BEEF_0BAD_F00D;
        bus.in2   = 64'd3;
      end
      if (bus.busy) begin
        busyCnt++;
        if (firstBusy < 0) firstBusy = c;
      end
      if (bus.done) begin
        doneCyc = c;
        break;
      end
    end
    @(negedge clk);
    pulseOk = !bus.done;
  endtask

  vec_t vecs [9];

  initial begin
    int  doneCyc;
    int  busyCnt;
    int  firstBusy;
    bit  pulseOk;
    int  lat;
    int  extraDone;

    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;

    vecs[0] = '{"100/7",      64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0};
    vecs[1] = '{"max/1",      '1, 64'd1, '1, 64'd0, 1'b0, 1'b0};
    vecs[2] = '{"max/max",    '1, '1, 64'd1, 64'd0, 1'b0, 1'b0};
    vecs[3] = '{"5/0",        64'd5, 64'd0, '1, 64'd5, 1'b0, 1'b1};
    vecs[4] = '{"3/10",       64'd3, 64'd10, 64'd0, 64'd3, 1'b1, 1'b0};
    vecs[5] = '{"81/9",       64'd81, 64'd9, 64'd9, 64'd0, 1'b0, 1'b0};
    vecs[6] = '{"msb/3",      64'h8000_0000_0000_0000, 64'd3,
                64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 1'b0};
    vecs[7] = '{"pat/16",     64'h1234_5678_9ABC_DEF7, 64'd16,
                64'h0123_4567_89AB_CDEF, 64'd7, 1'b0, 1'b0};
    vecs[8] = '{"0/5",        64'd0, 64'd5, 64'd0, 64'd0, 1'b1, 1'b0};

    // Reset values while reset is held.
    #12;
    checkOutput("rst busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("rst done", {63'd0, bus.done}, 64'd0);
    checkOutput("rst quot", bus.quot, 64'd0);
    checkOutput("rst rem", bus.rem, 64'd0);
    checkOutput("rst z", {63'd0, bus.z_div_flag}, 64'd1);
    checkOutput("rst dz", {63'd0, bus.dz_div_flag}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven divisions.
    for (int i = 0; i < 9; i++) begin
      lat = expLatency(vecs[i].a, vecs[i].b);
      applyStimulus(vecs[i].a, vecs[i].b, doneCyc, busyCnt, firstBusy, pulseOk);
      checkOutput({vecs[i].name, " doneCyc"}, 64'(doneCyc), 64'(lat));
      checkOutput({vecs[i].name, " busyCnt"}, 64'(busyCnt), (lat == 65) ? 64'd64 : 64'd0);
      if (lat == 65)
        checkOutput({vecs[i].name, " firstBusy"}, 64'(firstBusy), 64'd1);
      checkOutput({vecs[i].name, " pulse"}, {63'd0, pulseOk}, 64'd1);
      checkOutput({vecs[i].name, " quot"}, bus.quot, vecs[i].q);
      checkOutput({vecs[i].name, " rem"}, bus.rem, vecs[i].r);
      checkOutput({vecs[i].name, " z"}, {63'd0, bus.z_div_flag}, {63'd0, vecs[i].z});
      checkOutput({vecs[i].name, " dz"}, {63'd0, bus.dz_div_flag}, {63'd0, vecs[i].dz});
    end

    // A start raised in cycle 10 of a running 100/7 must be dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 64'd100;
    bus.in2   = 64'd7;
    @(posedge clk);
    doneCyc   = -1;
    extraDone = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      bus.start = (c == 10);
      if (c == 10) begin
        bus.in1 = 64'd9;
        bus.in2 = 64'd3;
      end
      if (bus.done) begin
        if (doneCyc < 0) doneCyc = c;
        else extraDone++;
      end
      if (c >= 150) break;
    end
    checkOutput("busyStart doneCyc", 64'(doneCyc), 64'd65);
    checkOutput("busyStart extraDone", 64'(extraDone), 64'd0);
    checkOutput("busyStart quot", bus.quot, 64'd14);
    checkOutput("busyStart rem", bus.rem, 64'd2);

    // Reset asserted in cycle 30 of a running division.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 64'd100;
    bus.in2   = 64'd7;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checkOutput("midrun busy", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("midrst done", {63'd0, bus.done}, 64'd0);
    checkOutput("midrst quot", bus.quot, 64'd0);
    checkOutput("midrst rem", bus.rem, 64'd0);
    checkOutput("midrst z", {63'd0, bus.z_div_flag}, 64'd1);
    checkOutput("midrst dz", {63'd0, bus.dz_div_flag}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(64'd81, 64'd9, doneCyc, busyCnt, firstBusy, pulseOk);
    checkOutput("postrst doneCyc", 64'(doneCyc), 64'd65);
    checkOutput("postrst quot", bus.quot, 64'd9);
    checkOutput("postrst rem", bus.rem, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
